// File: rtl/tia_hsync_pkg.sv
// tia_hsync_pkg: shared constants and types for the TIA horizontal timing generator.
// Holds the LFSR width, the END wrap value, the decoded line-event states and
// the LFSR step function. The decode values are the states the step rule
// reaches at each index, walking from 000000.
// The optional extended-HBLANK feature is controlled by the TIA_HMOVE_EN macro.
package tia_hsync_pkg;

    localparam int HC_W = 6;

    // Phase values that produce the two strobes.
    localparam logic [1:0] PH_HPHI1 = 2'd1;
    localparam logic [1:0] PH_HPHI2 = 2'd3;

    // Index 56: the last state of the 57-state line.
    localparam logic [HC_W-1:0] HC_END   = 6'b001010;

    // Named line-event states (index in the comment).
    localparam logic [HC_W-1:0] HC_IDX0  = 6'b000000; // line start, SHB
    localparam logic [HC_W-1:0] HC_IDX4  = 6'b001111; // HSYNC on
    localparam logic [HC_W-1:0] HC_IDX8  = 6'b111011; // HSYNC off, burst on
    localparam logic [HC_W-1:0] HC_IDX12 = 6'b111100; // burst off
    localparam logic [HC_W-1:0] HC_IDX16 = 6'b001110; // normal HBLANK end
    localparam logic [HC_W-1:0] HC_IDX18 = 6'b111010; // extended HBLANK end
    localparam logic [HC_W-1:0] HC_IDX36 = 6'b001101; // line center, CNT

    // Registered line-event outputs.
    typedef struct packed {
        logic shb;
        logic cnt;
        logic hsync;
        logic hblank;
        logic cburst;
    } hline_t;

    localparam hline_t LINE_RESET = '{shb: 1'b0, cnt: 1'b0, hsync: 1'b0,
                                      hblank: 1'b1, cburst: 1'b0};

    // One step of the horizontal LFSR: shift left, feed back XNOR of the top bits.
    function automatic logic [HC_W-1:0] lfsr_step(input logic [HC_W-1:0] v);
        return {v[HC_W-2:0], ~(v[HC_W-1] ^ v[HC_W-2])};
    endfunction

endpackage

// File: rtl/tia_hphase.sv
// tia_hphase: free-running two-bit phase counter and the non-overlapping
// phase strobes. hphi1 is high at phase 1, hphi2 at phase 3, so the two are
// never high together and there are always two clocks from hphi1 to hphi2.
// Shared by the horizontal, vertical and object counters.
module tia_hphase
    import tia_hsync_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    output logic [1:0] ph_o,
    output logic       hphi1_o,
    output logic       hphi2_o
);

    logic [1:0] ph_q;
    logic [1:0] ph_d;

    // Phase advances every clock and wraps 3 -> 0 by overflow.
    always_comb begin
        ph_d = ph_q + 2'd1;
    end

    // Phase register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph_q <= 2'd0;
        end else begin
            ph_q <= ph_d;
        end
    end

    assign ph_o    = ph_q;
    assign hphi1_o = (ph_q == PH_HPHI1);
    assign hphi2_o = (ph_q == PH_HPHI2);

endmodule

// File: rtl/tia_hsync_counter.sv
// tia_hsync_counter: TIA horizontal timing generator.
// Produces the HPHI1/HPHI2 strobes, runs the 57-state horizontal LFSR (one
// step per hphi2 clock, 228 clocks per line) and registers the decoded line
// events SHB, CNT, HSYNC, HBLANK and CBURST.
// rsync forces the line back to index 0 on the next hphi2 edge (or the same
// edge if it coincides). Defining TIA_HMOVE_EN enables the hmove-driven
// extension of HBLANK from index 16 to index 18; otherwise hmove is ignored.
module tia_hsync_counter
    import tia_hsync_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            rsync,
    input  logic            hmove,
    output logic            hphi1,
    output logic            hphi2,
    output logic [HC_W-1:0] hcount,
    output logic            shb,
    output logic            cnt,
    output logic            hsync,
    output logic            hblank,
    output logic            cburst
);

    logic [1:0]      unused_ph;
    logic [HC_W-1:0] hcount_q;
    logic [HC_W-1:0] hcount_d;
    logic            rsync_pend_q;
    logic            rsync_pend_d;
    hline_t          line_q;
    hline_t          line_d;
    logic            hit_idx0;
    logic            extend;

    tia_hphase u_hphase (
        .clk     (clk),
        .reset_n (reset_n),
        .ph_o    (unused_ph),
        .hphi1_o (hphi1),
        .hphi2_o (hphi2)
    );

    // Counter next state: a pending or coincident rsync beats the END wrap,
    // which beats the plain LFSR step. rsync between steps is remembered.
    always_comb begin
        hcount_d     = hcount_q;
        rsync_pend_d = rsync_pend_q;
        if (hphi2) begin
            if (rsync || rsync_pend_q) begin
                hcount_d = HC_IDX0;
            end else if (hcount_q == HC_END) begin
                hcount_d = HC_IDX0;
            end else begin
                hcount_d = lfsr_step(hcount_q);
            end
            rsync_pend_d = 1'b0;
        end else if (rsync) begin
            rsync_pend_d = 1'b1;
        end
    end

    assign hit_idx0 = hphi2 && (hcount_d == HC_IDX0);

`ifdef TIA_HMOVE_EN
    logic ext_q;
    logic ext_d;
    logic ext_next_q;
    logic ext_next_d;

    // hmove while the line is still blanking extends this line; a later one
    // is held and becomes the extend flag at the next index 0.
    always_comb begin
        ext_d      = ext_q;
        ext_next_d = ext_next_q;
        if (hmove) begin
            if (line_q.hblank) begin
                ext_d = 1'b1;
            end else begin
                ext_next_d = 1'b1;
            end
        end
        if (hit_idx0) begin
            ext_d      = ext_next_q | hmove;
            ext_next_d = 1'b0;
        end
    end

    // Extend flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ext_q      <= 1'b0;
            ext_next_q <= 1'b0;
        end else begin
            ext_q      <= ext_d;
            ext_next_q <= ext_next_d;
        end
    end

    assign extend = ext_d;
`else
    logic unused_hmove;
    assign unused_hmove = hmove;
    assign extend       = 1'b0;
`endif

    // Line events decode from the state being entered; shb/cnt last one clock.
    always_comb begin
        line_d     = line_q;
        line_d.shb = 1'b0;
        line_d.cnt = 1'b0;
        if (hphi2) begin
            if (hit_idx0) begin
                line_d.shb    = 1'b1;
                line_d.hblank = 1'b1;
            end
            if (hcount_d == HC_IDX4) begin
                line_d.hsync = 1'b1;
            end
            if (hcount_d == HC_IDX8) begin
                line_d.hsync  = 1'b0;
                line_d.cburst = 1'b1;
            end
            if (hcount_d == HC_IDX12) begin
                line_d.cburst = 1'b0;
            end
            if ((hcount_d == HC_IDX16) && !extend) begin
                line_d.hblank = 1'b0;
            end
            if ((hcount_d == HC_IDX18) && extend) begin
                line_d.hblank = 1'b0;
            end
            if (hcount_d == HC_IDX36) begin
                line_d.cnt = 1'b1;
            end
        end
    end

    // Counter, rsync flag and line-event registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcount_q     <= HC_IDX0;
            rsync_pend_q <= 1'b0;
            line_q       <= LINE_RESET;
        end else begin
            hcount_q     <= hcount_d;
            rsync_pend_q <= rsync_pend_d;
            line_q       <= line_d;
        end
    end

    assign hcount = hcount_q;
    assign shb    = line_q.shb;
    assign cnt    = line_q.cnt;
    assign hsync  = line_q.hsync;
    assign hblank = line_q.hblank;
    assign cburst = line_q.cburst;

endmodule

// File: tb/tb_tia_hsync_counter.sv
// tb_tia_hsync_counter: directed bench for the TIA horizontal timing generator.
// kk counts rising edges since the last reset release; outputs are sampled on
// the falling edge, so at sample kk the phase is kk%4 and the index kk/4.
module tb_tia_hsync_counter;

    typedef struct {
        int         k;
        logic [5:0] hc;
        logic [4:0] lv;   // {hsync, hblank, cburst, shb, cnt}
    } vec_t;

    localparam int NV = 20;
`ifdef TIA_HMOVE_EN
    localparam int  EXT_BLANK = 72;
    localparam logic EXT_MID  = 1'b1;
`else
    localparam int  EXT_BLANK = 64;
    localparam logic EXT_MID  = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic       rsync;
    logic       hmove;
    logic       hphi1;
    logic       hphi2;
    logic [5:0] hcount;
    logic       shb;
    logic       cnt;
    logic       hsync;
    logic       hblank;
    logic       cburst;

    int total;
    int bad;
    int kk;
    int phase_err;
    int overlap_err;
    int hs_hi;
    int cb_hi;
    int hb_hi;
    int shb_n;
    bit walk_chk;
    bit shb_track;

    logic [31:0] exp_q[$];
    logic [5:0]  seq [57];
    vec_t        vecs [NV];

    tia_hsync_counter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rsync   (rsync),
        .hmove   (hmove),
        .hphi1   (hphi1),
        .hphi2   (hphi2),
        .hcount  (hcount),
        .shb     (shb),
        .cnt     (cnt),
        .hsync   (hsync),
        .hblank  (hblank),
        .cburst  (cburst)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (kk=%0d)", name, got, exp, kk);
        end
    endtask

    task automatic clear_acc();
        hs_hi = 0;
        cb_hi = 0;
        hb_hi = 0;
        shb_n = 0;
    endtask

    // One clock: edge, then sample on the falling edge and accumulate.
    task automatic tick();
        @(posedge clk);
        kk++;
        @(negedge clk);
        if (hphi1 !== ((kk % 4) == 1) || hphi2 !== ((kk % 4) == 3)) phase_err++;
        if (hphi1 && hphi2) overlap_err++;
        if (hsync)  hs_hi++;
        if (cburst) cb_hi++;
        if (hblank) hb_hi++;
        if (shb) begin
            shb_n++;
            if (shb_track) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL shb_extra: pulse at kk=%0d, none expected", kk);
                end else begin
                    check("shb_time", kk, exp_q.pop_front());
                end
            end
        end
        if (walk_chk) check("hcount_walk", {26'd0, hcount}, {26'd0, seq[(kk / 4) % 57]});
    endtask

    task automatic run_to(input int target);
        while (kk < target) tick();
    endtask

    function automatic logic [4:0] lv_now();
        return {hsync, hblank, cburst, shb, cnt};
    endfunction

    initial begin
        seq = '{6'b000000, 6'b000001, 6'b000011, 6'b000111, 6'b001111, 6'b011111,
                6'b111110, 6'b111101, 6'b111011, 6'b110111, 6'b101111, 6'b011110,
                6'b111100, 6'b111001, 6'b110011, 6'b100111, 6'b001110, 6'b011101,
                6'b111010, 6'b110101, 6'b101011, 6'b010110, 6'b101100, 6'b011000,
                6'b110000, 6'b100001, 6'b000010, 6'b000101, 6'b001011, 6'b010111,
                6'b101110, 6'b011100, 6'b111000, 6'b110001, 6'b100011, 6'b000110,
                6'b001101, 6'b011011, 6'b110110, 6'b101101, 6'b011010, 6'b110100,
                6'b101001, 6'b010010, 6'b100100, 6'b001000, 6'b010001, 6'b100010,
                6'b000100, 6'b001001, 6'b010011, 6'b100110, 6'b001100, 6'b011001,
                6'b110010, 6'b100101, 6'b001010};
        vecs[0]  = '{0,   6'b000000, 5'b01000};
        vecs[1]  = '{1,   6'b000000, 5'b01000};
        vecs[2]  = '{3,   6'b000000, 5'b01000};
        vecs[3]  = '{4,   6'b000001, 5'b01000};
        vecs[4]  = '{8,   6'b000011, 5'b01000};
        vecs[5]  = '{12,  6'b000111, 5'b01000};
        vecs[6]  = '{16,  6'b001111, 5'b11000};
        vecs[7]  = '{31,  6'b111101, 5'b11000};
        vecs[8]  = '{32,  6'b111011, 5'b01100};
        vecs[9]  = '{47,  6'b011110, 5'b01100};
        vecs[10] = '{48,  6'b111100, 5'b01000};
        vecs[11] = '{63,  6'b100111, 5'b01000};
        vecs[12] = '{64,  6'b001110, 5'b00000};
        vecs[13] = '{144, 6'b001101, 5'b00001};
        vecs[14] = '{145, 6'b001101, 5'b00000};
        vecs[15] = '{224, 6'b001010, 5'b00000};
        vecs[16] = '{228, 6'b000000, 5'b01010};
        vecs[17] = '{229, 6'b000000, 5'b01000};
        vecs[18] = '{232, 6'b000001, 5'b01000};
        vecs[19] = '{456, 6'b000000, 5'b01010};

        total = 0; bad = 0; kk = 0; phase_err = 0; overlap_err = 0;
        walk_chk = 1'b0; shb_track = 1'b0;
        clear_acc();
        reset_n = 1'b0; rsync = 1'b0; hmove = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_hcount",  {26'd0, hcount}, 32'd0);
        check("reset_levels",  {27'd0, lv_now()}, {27'd0, 5'b01000});
        check("reset_strobes", {30'd0, hphi1, hphi2}, 32'd0);

        // Scenario 1/2: release and free-run two lines against the table.
        reset_n   = 1'b1;
        kk        = 0;
        walk_chk  = 1'b1;
        shb_track = 1'b1;
        exp_q.push_back(32'd228);
        exp_q.push_back(32'd456);
        for (int i = 0; i < NV; i++) begin
            run_to(vecs[i].k);
            check($sformatf("vec%0d_hcount", i), {26'd0, hcount}, {26'd0, vecs[i].hc});
            check($sformatf("vec%0d_levels", i), {27'd0, lv_now()}, {27'd0, vecs[i].lv});
            check($sformatf("vec%0d_strobes", i), {30'd0, hphi1, hphi2},
                  {30'd0, (vecs[i].k % 4) == 1, (vecs[i].k % 4) == 3});
            if (vecs[i].k == 228 || vecs[i].k == 456) begin
                check("line_hsync_clks",  hs_hi, 32'd16);
                check("line_cburst_clks", cb_hi, 32'd16);
                check("line_hblank_clks", hb_hi, 32'd64);
                clear_acc();
            end
        end
        check("shb_all_seen", exp_q.size(), 32'd0);
        walk_chk  = 1'b0;
        shb_track = 1'b0;

        // Scenario 3: rsync at index 30 of line 3 (line starts at kk=456).
        run_to(576);
        check("rs_pre_hcount", {26'd0, hcount}, {26'd0, seq[30]});
        rsync = 1'b1;
        tick();
        rsync = 1'b0;
        check("rs_wait_hcount", {26'd0, hcount}, {26'd0, seq[30]});
        run_to(580);
        check("rs_load_hcount", {26'd0, hcount}, 32'd0);
        check("rs_load_levels", {27'd0, lv_now()}, {27'd0, 5'b01010});
        tick();
        check("rs_after_strobes", {30'd0, hphi1, hphi2}, {30'd0, 2'b10});
        check("rs_after_shb", {31'd0, shb}, 32'd0);
        run_to(584);
        check("rs_next_step", {26'd0, hcount}, {26'd0, seq[1]});

        // Scenario 4: rsync coinciding with the END hphi2 edge.
        run_to(804);
        check("end_hcount", {26'd0, hcount}, {26'd0, seq[56]});
        run_to(807);
        check("end_pre_hphi2", {31'd0, hphi2}, 32'd1);
        clear_acc();
        rsync = 1'b1;
        tick();
        rsync = 1'b0;
        check("end_rs_hcount", {26'd0, hcount}, 32'd0);
        check("end_rs_levels", {27'd0, lv_now()}, {27'd0, 5'b01010});
        run_to(812);
        check("end_rs_step", {26'd0, hcount}, {26'd0, seq[1]});
        check("end_rs_shb_count", shb_n, 32'd1);

        // Scenario 5: hmove at index 5 of the line starting at kk=808.
        run_to(828);
        clear_acc();
        hb_hi = 1;  // index-5 sample region starts after kk=808; count from 809
        hb_hi = 0;
        check("hm_idx5", {26'd0, hcount}, {26'd0, seq[5]});
        hmove = 1'b1;
        tick();
        hmove = 1'b0;
        run_to(876);
        check("hm_idx17_hblank", {31'd0, hblank}, {31'd0, EXT_MID});
        run_to(884);
        check("hm_idx19_hblank", {31'd0, hblank}, 32'd0);
        run_to(1036);
        check("hm_line_hblank_clks", hb_hi + 20, EXT_BLANK);
        clear_acc();
        run_to(1264);
        check("hm_next_hblank_clks", hb_hi, 32'd64);
        check("phase_err", phase_err, 32'd0);
        check("overlap_err", overlap_err, 32'd0);

        // Scenario 6: reset while hsync is high, then restart.
        run_to(1285);
        check("mid_hsync", {31'd0, hsync}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_hcount",  {26'd0, hcount}, 32'd0);
        check("mid_rst_levels",  {27'd0, lv_now()}, {27'd0, 5'b01000});
        check("mid_rst_strobes", {30'd0, hphi1, hphi2}, 32'd0);
        repeat (2) @(negedge clk);
        check("mid_hold_all", {19'd0, hcount, lv_now(), hphi1, hphi2}, {19'd0, 6'd0, 5'b01000, 2'b00});
        reset_n = 1'b1;
        kk = 0;
        phase_err = 0;
        clear_acc();
        check("re_k0_levels", {27'd0, lv_now()}, {27'd0, 5'b01000});
        tick();
        check("re_k1_strobes", {30'd0, hphi1, hphi2}, {30'd0, 2'b10});
        run_to(3);
        check("re_k3_strobes", {30'd0, hphi1, hphi2}, {30'd0, 2'b01});
        check("re_k3_hcount", {26'd0, hcount}, 32'd0);
        run_to(4);
        check("re_k4_hcount", {26'd0, hcount}, {26'd0, seq[1]});
        run_to(16);
        check("re_k16_hcount", {26'd0, hcount}, {26'd0, seq[4]});
        check("re_k16_hsync", {31'd0, hsync}, 32'd1);
        check("re_no_shb", shb_n, 32'd0);
        check("re_phase_err", phase_err, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
